// File: rtl/me_stream_driver_pkg.sv
// Shared types and constants for the motion-estimation stream driver.
// State codes are plain constants so legacy tooling can decode them.
package me_pkg;

  localparam int WD_W  = 88;
  localparam int BUF_W = 32;
  localparam int VEC_W = 4;
  localparam int SRC_W = 32;

  localparam int N_WD_DEF  = 16;
  localparam int N_BUF_DEF = 256;
  localparam int LAT_DEF   = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD_WD  = 3'd1;
  localparam state_t ST_LOAD_BUF = 3'd2;
  localparam state_t ST_WAIT     = 3'd3;
  localparam state_t ST_RESULT   = 3'd4;

endpackage

// File: rtl/me_stream_driver_if.sv
// Source beat and result handshakes between the job producer/consumer and the driver.
interface me_stream_driver_if;
  import me_pkg::*;

  logic             src_valid;
  logic             src_ready;
  logic [SRC_W-1:0] src_data;
  logic             res_valid;
  logic             res_ready;
  logic [VEC_W-1:0] res_vx;
  logic [VEC_W-1:0] res_vy;

  modport master (
    output src_valid, src_data, res_ready,
    input  src_ready, res_valid, res_vx, res_vy
  );

  modport slave (
    input  src_valid, src_data, res_ready,
    output src_ready, res_valid, res_vx, res_vy
  );

endinterface

// File: rtl/me_stream_driver_wd_packer.sv
// Packs three 32-bit source beats into one 88-bit WriteData word.
// The top byte of the third beat does not fit and is dropped.
module me_wd_packer
  import me_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic             beat_valid,
  input  logic [SRC_W-1:0] beat_data,
  output logic             word_last,
  output logic [WD_W-1:0]  word
);

  logic [1:0]       beat_cnt_r;
  logic [SRC_W-1:0] lo_r;
  logic [SRC_W-1:0] mid_r;
  logic [WD_W-1:0]  word_r;

  assign word_last = (beat_cnt_r == 2'd2);
  assign word      = word_r;

  // Beat staging; the output word only changes on the closing beat.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      beat_cnt_r <= 2'd0;
      lo_r       <= {SRC_W{1'b0}};
      mid_r      <= {SRC_W{1'b0}};
      word_r     <= {WD_W{1'b0}};
    end else if (beat_valid) begin
      case (beat_cnt_r)
        2'd0: begin
          lo_r       <= beat_data;
          beat_cnt_r <= 2'd1;
        end
        2'd1: begin
          mid_r      <= beat_data;
          beat_cnt_r <= 2'd2;
        end
        2'd2: begin
          word_r     <= {beat_data[WD_W-2*SRC_W-1:0], mid_r, lo_r};
          beat_cnt_r <= 2'd0;
        end
        default: beat_cnt_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/me_stream_driver.sv
// Feeds WriteData words and search-window words to the ME core, waits out the
// core latency, then offers the captured motion vector on a result handshake.
module me_stream_driver
  import me_pkg::*;
#(
  parameter int N_WD  = N_WD_DEF,
  parameter int N_BUF = N_BUF_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  me_stream_driver_if.slave  stream,
  output logic [WD_W-1:0]    WriteData,
  output logic [BUF_W-1:0]   bufferData_in,
  output logic               core_resetn,
  input  logic [VEC_W-1:0]   vector_x,
  input  logic [VEC_W-1:0]   vector_y,
  output logic               busy
);

  localparam int WD_CW  = (N_WD  > 1) ? $clog2(N_WD)  : 1;
  localparam int BUF_CW = (N_BUF > 1) ? $clog2(N_BUF) : 1;
  localparam int LAT_CW = (LAT   > 0) ? $clog2(LAT + 1) : 1;

  state_t             state_r;
  logic [WD_CW-1:0]   wd_cnt_r;
  logic [BUF_CW-1:0]  buf_cnt_r;
  logic [LAT_CW-1:0]  lat_cnt_r;
  logic               src_ready_r;
  logic               res_valid_r;
  logic [VEC_W-1:0]   res_vx_r;
  logic [VEC_W-1:0]   res_vy_r;
  logic [BUF_W-1:0]   buf_data_r;
  logic               core_resetn_r;
  logic               busy_r;

  logic               accept_s;
  logic               wd_beat_s;
  logic               word_last_s;
  logic [WD_W-1:0]    wd_word_s;

  // src_ready is a register, so acceptance never feeds back into it combinationally.
  assign accept_s  = stream.src_valid & src_ready_r;
  assign wd_beat_s = accept_s & (state_r == ST_LOAD_WD);

  me_wd_packer u_packer (
    .CLK        (CLK),
    .reset      (reset),
    .beat_valid (wd_beat_s),
    .beat_data  (stream.src_data),
    .word_last  (word_last_s),
    .word       (wd_word_s)
  );

  assign WriteData        = wd_word_s;
  assign bufferData_in    = buf_data_r;
  assign core_resetn      = core_resetn_r;
  assign busy             = busy_r;
  assign stream.src_ready = src_ready_r;
  assign stream.res_valid = res_valid_r;
  assign stream.res_vx    = res_vx_r;
  assign stream.res_vy    = res_vy_r;

  // Job sequencer: counters and all handshake outputs move with the state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      wd_cnt_r      <= {WD_CW{1'b0}};
      buf_cnt_r     <= {BUF_CW{1'b0}};
      lat_cnt_r     <= {LAT_CW{1'b0}};
      src_ready_r   <= 1'b0;
      res_valid_r   <= 1'b0;
      res_vx_r      <= {VEC_W{1'b0}};
      res_vy_r      <= {VEC_W{1'b0}};
      buf_data_r    <= {BUF_W{1'b0}};
      core_resetn_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r       <= ST_LOAD_WD;
            src_ready_r   <= 1'b1;
            core_resetn_r <= 1'b1;
            busy_r        <= 1'b1;
          end
        end
        ST_LOAD_WD: begin
          if (accept_s && word_last_s) begin
            if (wd_cnt_r == WD_CW'(N_WD - 1)) begin
              wd_cnt_r <= {WD_CW{1'b0}};
              state_r  <= ST_LOAD_BUF;
            end else begin
              wd_cnt_r <= wd_cnt_r + WD_CW'(1);
            end
          end
        end
        ST_LOAD_BUF: begin
          if (accept_s) begin
            buf_data_r <= stream.src_data;
            if (buf_cnt_r == BUF_CW'(N_BUF - 1)) begin
              buf_cnt_r   <= {BUF_CW{1'b0}};
              src_ready_r <= 1'b0;
              state_r     <= ST_WAIT;
            end else begin
              buf_cnt_r <= buf_cnt_r + BUF_CW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (lat_cnt_r == LAT_CW'(LAT)) begin
            lat_cnt_r   <= {LAT_CW{1'b0}};
            res_vx_r    <= vector_x;
            res_vy_r    <= vector_y;
            res_valid_r <= 1'b1;
            state_r     <= ST_RESULT;
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_CW'(1);
          end
        end
        ST_RESULT: begin
          if (stream.res_ready) begin
            res_valid_r   <= 1'b0;
            core_resetn_r <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          src_ready_r   <= 1'b0;
          res_valid_r   <= 1'b0;
          core_resetn_r <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/me_stream_driver.md
ME_STREAM_DRIVER -- requirements
Module: me_stream_driver

Interface
REQ-001 Parameter N_WD, default 16, number of 88-bit WriteData words per job.
REQ-002 Parameter N_BUF, default 256, number of 32-bit bufferData_in words per job.
REQ-003 Parameter LAT, default 32, cycles from last buffer word to vector sampling.
REQ-004 CLK  in  1  single clock; one clock; reset is asynchronous and active-high.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse to begin a job; ignored unless idle.
REQ-007 src_valid / src_ready  in / out  1 / 1  source beat handshake.
REQ-008 src_data  in  32  source beat payload.
REQ-009 WriteData  out  88  packed word to ME core.
REQ-010 bufferData_in  out  32  search-window word to ME core.
REQ-011 core_resetn  out  1  active-low reset to ME core.
REQ-012 vector_x / vector_y  in  4 / 4  ME core result.
REQ-013 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-014 res_vx / res_vy  out  4 / 4  captured vector.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, LOAD_WD, LOAD_BUF, WAIT, RESULT; encoding in shared package.
REQ-017 IDLE: src_ready=0, core_resetn=0; start -> LOAD_WD, core_resetn=1 from next cycle.
REQ-018 Source beat accepted only when src_valid and src_ready both high at a CLK edge.
REQ-019 LOAD_WD: src_ready=1; three accepted beats form one word: beat0 -> bits[31:0], beat1 -> [63:32], beat2[23:0] -> [87:64], beat2[31:24] discarded.
REQ-020 WriteData updates only on the edge accepting beat2 of a word and holds otherwise.
REQ-021 After word N_WD-1 is loaded -> LOAD_BUF; beat counter (0..2) and word counter wrap to 0.
REQ-022 LOAD_BUF: src_ready=1; each accepted beat registers to bufferData_in on that edge; after beat N_BUF-1 -> WAIT.
REQ-023 src_valid low stalls LOAD_WD/LOAD_BUF indefinitely with outputs held.
REQ-024 WAIT: src_ready=0; counter runs LAT cycles, then vector_x/vector_y sampled into res_vx/res_vy; -> RESULT.
REQ-025 RESULT: res_valid=1, res_vx/res_vy stable until res_ready high; on handshake -> IDLE, res_valid=0 next cycle.
REQ-026 start while busy ignored, no effect on counters.
REQ-027 Minimum job length 3*N_WD + N_BUF + LAT + 2 cycles with continuous src_valid and res_ready.

Reset
REQ-028 Reset assertion at any cycle forces IDLE immediately, aborting an in-progress job.
REQ-029 Reset values: WriteData=0, bufferData_in=0, core_resetn=0, src_ready=0, res_valid=0, res_vx=0, res_vy=0, busy=0, all counters 0.
REQ-030 First start honoured on the first edge after reset deasserts.

Structure
REQ-031 Package me_pkg holds state enum, WD_W=88, BUF_W=32, VEC_W=4 and default parameter values.
REQ-032 One sub-module, me_wd_packer, performs REQ-019/020 beat-to-88-bit packing.
REQ-033 All outputs registered; no combinational path from src_valid to src_ready.

Verification
REQ-034 N_WD=2,N_BUF=4,LAT=3; beats 0x11111111,0x22222222,0xAABBCCDD -> WriteData=0xBBCCDD_22222222_11111111.
REQ-035 Same config, continuous traffic, vector_x=4'h5,vector_y=4'hB held -> res_valid at cycle 3*2+4+3+2 after start, res_vx=5,res_vy=B.
REQ-036 src_valid low 10 cycles mid-LOAD_BUF -> bufferData_in and counters unchanged, job completes with no lost beat.
REQ-037 res_ready low 20 cycles in RESULT -> res_valid=1, res_vx/res_vy stable, no new src_ready.
REQ-038 reset pulsed during LOAD_WD word 1 -> all outputs at REQ-029 values same cycle; fresh start loads word 0 from new beats.
REQ-039 start pulsed during WAIT -> ignored; exactly one result emitted, then IDLE.
